// File: rtl/trng_pkg.sv
// Shared types and default sizing for the ring-oscillator TRNG core.
package trng_pkg;

    typedef enum logic {
        VN_IDLE       = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_t;

    localparam int DEF_N_STAGES  = 5;
    localparam int DEF_REP_LIMIT = 16;
    localparam int DEF_OUT_W     = 8;

endpackage

// File: rtl/ro_chain.sv
// One enable-gated ring oscillator: AND gate followed by an odd inverter chain.
module ro_chain
    import trng_pkg::*;
#(
    parameter int N_STAGES = DEF_N_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic ro_out
);

    logic fb_q;
    logic gate;

    // The ring is closed through fb_q so no zero-delay loop exists in the netlist model.
    assign gate = en & fb_q;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_inv
        logic stage_in;
        logic stage_out;
        if (g == 0) begin : g_first
            assign stage_in = gate;
        end else begin : g_next
            assign stage_in = g_inv[g-1].stage_out;
        end
        assign stage_out = ~stage_in;
    end

    assign ro_out = g_inv[N_STAGES-1].stage_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fb_q <= 1'b0;
        else        fb_q <= ro_out;
    end

endmodule

// File: rtl/ro_trng_core.sv
// Multi-channel ring-oscillator entropy source: sample, debias, health-check, pack.
module ro_trng_core
    import trng_pkg::*;
#(
    parameter int N_RO      = 4,
    parameter int N_STAGES  = DEF_N_STAGES,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int DIV_W     = 8,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_activate,
    input  logic [DIV_W-1:0] div,
    input  logic             vn_en,
    input  logic             test_mode,
    input  logic             test_bit,
    input  logic             rnd_ready,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    output logic             health_fail,
    output logic [N_RO-1:0]  ro_raw
);

    localparam int CW = $clog2(OUT_W + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OUT_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);
    localparam logic [RW-1:0] REP_ONE  = RW'(1);

    logic [N_RO-1:0]  ro_osc, sync1;
    logic [DIV_W-1:0] div_cnt, div_lat, div_eff;
    logic             tick, raw_q, raw_vld;
    logic             prev_bit, have_prev, rep_hit, fail_now;
    logic [RW-1:0]    rep_cnt, rep_next;
    vn_state_t        vn_state, vn_next;
    logic             vn_en_q, first_bit, capture_first, emit, emit_bit;
    logic [OUT_W-1:0] col, col_n, word;
    logic [CW-1:0]    bit_cnt, cnt_n;
    logic             can_xfer, load, valid_n;

    for (genvar ch = 0; ch < N_RO; ch++) begin : g_ro
        ro_chain #(.N_STAGES(N_STAGES)) u_ro (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (ro_activate),
            .ro_out (ro_osc[ch])
        );
    end

    // NOTE: clocked state uses <= so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            ro_raw  <= '0;
            vn_en_q <= 1'b0;
        end else begin
            sync1   <= ro_osc;
            ro_raw  <= sync1;
            vn_en_q <= vn_en;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        div_eff = (div_cnt == '0) ? div : div_lat;
        tick    = ro_activate && (div_cnt == div_eff);
    end

    always_comb begin
        rep_next = REP_ONE;
        if (have_prev && (raw_q == prev_bit))
            rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
        rep_hit  = raw_vld && (rep_next == REP_MAX);
        fail_now = health_fail || rep_hit;
    end

    // Debiaser; a change of vn_en restarts pairing from IDLE.
    always_comb begin
        vn_next       = vn_state;
        emit          = 1'b0;
        emit_bit      = raw_q;
        capture_first = 1'b0;
        if (vn_en != vn_en_q) begin
            vn_next = VN_IDLE;
            emit    = raw_vld && !vn_en;
        end else if (raw_vld) begin
            if (!vn_en) begin
                emit = 1'b1;
            end else if (vn_state == VN_IDLE) begin
                capture_first = 1'b1;
                vn_next       = VN_HAVE_FIRST;
            end else begin
                emit     = (raw_q != first_bit);
                emit_bit = first_bit;
                vn_next  = VN_IDLE;
            end
        end
    end

    // A word completed by this cycle's bit may leave at once, giving the two-cycle latency.
    always_comb begin
        can_xfer = !fail_now && (!rnd_valid || rnd_ready);
        col_n    = col;
        cnt_n    = bit_cnt;
        load     = 1'b0;
        word     = col;
        if (bit_cnt == CNT_FULL) begin
            if (can_xfer) begin
                load  = 1'b1;
                col_n = {col[OUT_W-2:0], emit_bit};
                cnt_n = emit ? CNT_ONE : '0;
            end
        end else if (emit) begin
            col_n = {col[OUT_W-2:0], emit_bit};
            if (bit_cnt == CNT_LAST && can_xfer) begin
                load  = 1'b1;
                word  = col_n;
                cnt_n = '0;
            end else begin
                cnt_n = bit_cnt + 1'b1;
            end
        end
        valid_n = load ? 1'b1 : (rnd_ready ? 1'b0 : rnd_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            div_lat     <= '0;
            raw_q       <= 1'b0;
            raw_vld     <= 1'b0;
            prev_bit    <= 1'b0;
            have_prev   <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            vn_state    <= VN_IDLE;
            first_bit   <= 1'b0;
            // NOTE: collector data is cleared too so a dropped partial word never resurfaces.
            col         <= '0;
            bit_cnt     <= '0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
        end else if (!ro_activate) begin
            div_cnt     <= '0;
            div_lat     <= '0;
            raw_q       <= 1'b0;
            raw_vld     <= 1'b0;
            prev_bit    <= 1'b0;
            have_prev   <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            vn_state    <= VN_IDLE;
            first_bit   <= 1'b0;
            col         <= '0;
            bit_cnt     <= '0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
        end else begin
            if (div_cnt == '0) div_lat <= div;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            raw_vld <= tick;
            if (tick) raw_q <= test_mode ? test_bit : ^ro_raw;
            if (raw_vld) begin
                prev_bit  <= raw_q;
                have_prev <= 1'b1;
                rep_cnt   <= rep_next;
            end
            health_fail <= fail_now;
            vn_state    <= vn_next;
            if (capture_first) first_bit <= raw_q;
            col       <= col_n;
            bit_cnt   <= cnt_n;
            if (load) rnd_data <= word;
            rnd_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_ro_trng_core.sv
// Self-checking bench for ro_trng_core driven through the test_mode sample path.
module tb_ro_trng_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ro_activate;
    logic [7:0] div;
    logic       vn_en, test_mode, test_bit, rnd_ready;
    logic [7:0] rnd_data;
    logic       rnd_valid, health_fail;
    logic [3:0] ro_raw;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic       raw_bits[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       exp_fail;

    ro_trng_core #(
        .N_RO(4), .N_STAGES(5), .OUT_W(8), .DIV_W(8), .REP_LIMIT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_activate (ro_activate),
        .div         (div),
        .vn_en       (vn_en),
        .test_mode   (test_mode),
        .test_bit    (test_bit),
        .rnd_ready   (rnd_ready),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .health_fail (health_fail),
        .ro_raw      (ro_raw)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && rnd_valid && rnd_ready) got_q.push_back(rnd_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic deact();
        ro_activate = 1'b0;
        cyc();
    endtask

    // Reference: pair-wise debiasing, run-length health test, MSB-first packing, consumer always ready.
    function automatic void model(input logic vn);
        int         rep = 0;
        logic       prev = 1'b0;
        logic       first = 1'b0;
        logic       have_first = 1'b0;
        logic [7:0] acc = 8'h00;
        int         cnt = 0;
        exp_q.delete();
        exp_fail = 1'b0;
        foreach (raw_bits[i]) begin
            logic b, e, eb;
            b   = raw_bits[i];
            rep = (i > 0 && b == prev) ? rep + 1 : 1;
            prev = b;
            if (rep >= 16) exp_fail = 1'b1;
            e  = 1'b0;
            eb = b;
            if (!vn) e = 1'b1;
            else if (!have_first) begin first = b; have_first = 1'b1; end
            else begin e = (b != first); eb = first; have_first = 1'b0; end
            if (e && cnt < 8) begin
                acc = {acc[6:0], eb};
                cnt++;
                if (cnt == 8 && !exp_fail) begin
                    exp_q.push_back(acc);
                    cnt = 0;
                end
            end
        end
    endfunction

    // Each raw bit is held for one full sample period, starting at activation.
    task automatic run_bits(input int d, input logic vn);
        got_q.delete();
        div       = 8'(d);
        vn_en     = vn;
        rnd_ready = 1'b1;
        test_mode = 1'b1;
        foreach (raw_bits[i]) begin
            ro_activate = 1'b1;
            test_bit    = raw_bits[i];
            repeat (d + 1) cyc();
        end
        div = 8'hFF;
        repeat (6) cyc();
    endtask

    task automatic compare_model(input string tag, input logic vn);
        model(vn);
        check({tag, "_words"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_health"}, health_fail, exp_fail);
    endtask

    initial begin
        logic [7:0] pat;
        rst_n = 1'b0; ro_activate = 1'b0; div = 8'h00; vn_en = 1'b0;
        test_mode = 1'b1; test_bit = 1'b0; rnd_ready = 1'b1;
        repeat (3) cyc();
        check("rst_valid", rnd_valid, 1'b0);
        check("rst_data", rnd_data, 8'h00);
        check("rst_health", health_fail, 1'b0);
        check("rst_ro_raw", ro_raw, 4'h0);
        rst_n = 1'b1;
        cyc();

        // Basic packing and two-cycle latency at div=0.
        got_q.delete();
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            ro_activate = 1'b1;
            test_bit    = pat[7-i];
            cyc();
        end
        test_bit = 1'b0;
        check("b2_not_early", rnd_valid, 1'b0);
        test_bit = 1'b1;
        cyc();
        check("b2_valid", rnd_valid, 1'b1);
        check("b2_data", rnd_data, 8'hB2);
        test_bit = 1'b0;
        cyc();
        check("b2_one_cycle", rnd_valid, 1'b0);
        deact();
        check("deact_valid", rnd_valid, 1'b0);

        // Divider plus debiaser: discordant pairs emit, concordant pairs are dropped.
        raw_bits = '{1,0, 1,1, 1,0, 0,0, 1,0, 1,0, 1,1, 1,0, 0,0, 1,0, 1,0, 1,0};
        run_bits(3, 1'b1);
        check("vn_count", got_q.size(), 1);
        if (got_q.size() > 0) check("vn_data", got_q[0], 8'hFF);
        compare_model("vn", 1'b1);
        deact();

        // Backpressure: second word waits, later bits are discarded.
        got_q.delete();
        div = 8'h00; vn_en = 1'b0; rnd_ready = 1'b0;
        pat = 8'hB2;
        for (int i = 0; i < 24; i++) begin
            ro_activate = 1'b1;
            test_bit    = (i < 8) ? pat[7-i] : (i < 16) ? 1'b1 : i[0];
            cyc();
        end
        check("bp_hold_valid", rnd_valid, 1'b1);
        check("bp_hold_data", rnd_data, 8'hB2);
        rnd_ready = 1'b1;
        test_bit  = 1'b0;
        cyc();
        check("bp_next_valid", rnd_valid, 1'b1);
        check("bp_next_data", rnd_data, 8'hFF);
        test_bit = 1'b1;
        cyc();
        check("bp_drop", rnd_valid, 1'b0);
        check("bp_words", got_q.size(), 2);
        deact();

        // Health: a run of 16 equal samples latches health_fail and blocks the second word.
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            ro_activate = 1'b1;
            test_bit    = 1'b1;
            cyc();
        end
        check("hf_before", health_fail, 1'b0);
        cyc();
        check("hf_set", health_fail, 1'b1);
        repeat (10) cyc();
        check("hf_words", got_q.size(), 1);
        if (got_q.size() > 0) check("hf_first_word", got_q[0], 8'hFF);
        check("hf_blocked", rnd_valid, 1'b0);
        check("hf_sticky", health_fail, 1'b1);
        deact();
        check("hf_cleared", health_fail, 1'b0);

        // Deactivation mid-word discards the partial word.
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            ro_activate = 1'b1;
            test_bit    = 1'b1;
            cyc();
        end
        deact();
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            ro_activate = 1'b1;
            test_bit    = pat[7-i];
            cyc();
        end
        test_bit = 1'b1;
        cyc();
        check("react_valid", rnd_valid, 1'b1);
        check("react_data", rnd_data, 8'h5A);
        check("react_words", got_q.size(), 0);
        deact();

        // Randomised sequences against the reference model.
        for (int it = 0; it < 5; it++) begin
            int   d;
            logic vn;
            logic b;
            d  = $urandom_range(0, 3);
            vn = 1'($urandom_range(0, 1));
            raw_bits.delete();
            b = 1'($urandom_range(0, 1));
            for (int i = 0; i < 96; i++) begin
                if (it == 4) begin
                    if ($urandom_range(0, 7) == 0) b = ~b;
                end else begin
                    b = 1'($urandom_range(0, 1));
                end
                raw_bits.push_back(b);
            end
            run_bits(d, vn);
            compare_model($sformatf("rand%0d", it), vn);
            deact();
        end

        // Asynchronous reset mid-cycle while a word is pending.
        got_q.delete();
        div = 8'h00; vn_en = 1'b0; rnd_ready = 1'b0;
        pat = 8'hB2;
        for (int i = 0; i < 10; i++) begin
            ro_activate = 1'b1;
            test_bit    = (i < 8) ? pat[7-i] : 1'b0;
            cyc();
        end
        check("ar_pre_valid", rnd_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", rnd_valid, 1'b0);
        check("ar_data", rnd_data, 8'h00);
        check("ar_health", health_fail, 1'b0);
        check("ar_ro_raw", ro_raw, 4'h0);
        ro_activate = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
